// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcodes, state encoding, field helpers.
package instruction_sequencer_pkg;

   // Sequencer states; HALT is the reset state.
   typedef enum logic [1:0] {
      StHalt  = 2'b00,
      StFetch = 2'b01,
      StImm   = 2'b10,
      StExec  = 2'b11
   } seq_state_e;

   localparam logic [4:0] OpNop  = 5'b00000;
   localparam logic [4:0] OpMov  = 5'b00001;
   localparam logic [4:0] OpImm  = 5'b00010;
   localparam logic [4:0] OpHalt = 5'b11111;

   function automatic logic [4:0] inst_opcode(input logic [7:0] inst);
      return inst[7:3];
   endfunction

   function automatic logic [2:0] inst_reg(input logic [7:0] inst);
      return inst[2:0];
   endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Program-memory handshake plus ControlUnit-facing outputs of the sequencer.
interface instruction_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  run;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [7:0]            mem_data;
   logic [7:0]            inst;
   logic [7:0]            imm_data;
   logic                  ctrl_rst;
   logic                  exec_strobe;
   logic                  halted;

   // Sequencer side.
   modport master (
      input  run, mem_ack, mem_data,
      output mem_req, mem_addr, inst, imm_data, ctrl_rst, exec_strobe, halted
   );

   // Memory / CPU environment side.
   modport slave (
      output run, mem_ack, mem_data,
      input  mem_req, mem_addr, inst, imm_data, ctrl_rst, exec_strobe, halted
   );
endinterface

// File: rtl/instruction_sequencer_program_counter.sv
// Program counter: wraps modulo 2^ADDR_WIDTH, async active-low reset to RESET_PC.
module instruction_sequencer_program_counter #(
   parameter int unsigned          ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] pc
);
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   // Next PC: increment on every accepted memory beat, natural wrap.
   always_comb begin
      pc_d = pc_q;
      if (inc) begin
         pc_d = pc_q + 1'b1;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;
endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer: owns run/halt state, IR and immediate, drives ControlUnit reset.
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [4:0]           IMM_OPCODE  = OpImm,
   parameter logic [4:0]           HALT_OPCODE = OpHalt
) (
   input  logic                    clk,
   input  logic                    rst,
   instruction_sequencer_if.master bus
);
   seq_state_e            state_q;
   seq_state_e            state_d;
   logic [7:0]            ir_q;
   logic [7:0]            ir_d;
   logic [7:0]            imm_q;
   logic [7:0]            imm_d;
   logic                  fetching;
   logic                  beat;
   logic [ADDR_WIDTH-1:0] pc;

   // A memory beat is only accepted while a request is outstanding.
   assign fetching = (state_q == StFetch) || (state_q == StImm);
   assign beat     = fetching && bus.mem_ack;

   instruction_sequencer_program_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc (
      .clk (clk),
      .rst (rst),
      .inc (beat),
      .pc  (pc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StHalt;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: HALT opcode skips EXEC, IMM opcode pulls one extra byte.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHalt: begin
            if (bus.run) state_d = StFetch;
         end
         StFetch: begin
            if (bus.mem_ack) begin
               if (inst_opcode(bus.mem_data) == IMM_OPCODE) begin
                  state_d = StImm;
               end else if (inst_opcode(bus.mem_data) == HALT_OPCODE) begin
                  state_d = StHalt;
               end else begin
                  state_d = StExec;
               end
            end
         end
         StImm: begin
            if (bus.mem_ack) state_d = StExec;
         end
         StExec: begin
            state_d = bus.run ? StFetch : StHalt;
         end
         default: state_d = StHalt;
      endcase
   end

   // IR / immediate capture on accepted beats.
   always_comb begin
      ir_d  = ir_q;
      imm_d = imm_q;
      if (beat && (state_q == StFetch)) ir_d  = bus.mem_data;
      if (beat && (state_q == StImm))   imm_d = bus.mem_data;
   end

   // IR and immediate registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_q  <= 8'h00;
         imm_q <= 8'h00;
      end else begin
         ir_q  <= ir_d;
         imm_q <= imm_d;
      end
   end

   // Outputs decoded from the state register only, so they cannot glitch.
   always_comb begin
      bus.mem_req     = 1'b0;
      bus.ctrl_rst    = 1'b1;
      bus.exec_strobe = 1'b0;
      bus.halted      = 1'b0;
      unique case (state_q)
         StHalt:  bus.halted  = 1'b1;
         StFetch: bus.mem_req = 1'b1;
         StImm:   bus.mem_req = 1'b1;
         StExec: begin
            bus.ctrl_rst    = 1'b0;
            bus.exec_strobe = 1'b1;
         end
         default: bus.halted = 1'b1;
      endcase
   end

   assign bus.mem_addr = pc;
   assign bus.inst     = ir_q;
   assign bus.imm_data = imm_q;
endmodule
